mau_controller: RTL
===================

Name: mau_controller

Overview:
- Host-side initiator for the CPU's memory access unit (MAU) ports. It loads instruction memory, data memory and the register file while the CPU is held in reset (alive=0), then raises alive and counts cycles until halt or a timeout.
- It reads back results through the same MAU ports and returns them on a valid/ready response stream.
- It sits between the host command link and the CPU's mau_*, alive and halt pins.

Parameters:
- RD_LAT, 1, cycles from mau_address change to valid mau_read_data_* (1..3)
- MAX_CYCLES, 32'h00FF_FFFF, RUN timeout in clk cycles

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command word valid
- cmd_ready  out  1  controller accepts cmd_data this cycle
- cmd_data  in  32  command stream word
- rsp_valid  out  1  response word valid
- rsp_ready  in  1  host accepts rsp_data
- rsp_data  out  32  response word
- mau_address_im/_dm/_rf  out  32 each  byte address to IM/DM/RF
- mau_write_data_im/_dm/_rf  out  32 each  write data
- mau_wren_im/_dm/_rf  out  1 each  write strobe, single-cycle pulse
- mau_read_data_im/_dm/_rf  in  32 each  read data
- alive  out  1  CPU run enable; 0 holds the CPU in reset and grants MAU access
- halt  in  1  CPU halt indication

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, alive=0, all mau_* outputs 0, rsp_valid=0, rsp_data=0, cycle counter 0. cmd_ready is a decode of state, so it reads 1 in IDLE.
- Handshakes: a transfer occurs when valid&ready are both high on a rising edge. rsp_valid stays high and rsp_data stays stable until rsp_ready. cmd_ready=1 only in IDLE, ADDR and WR_DATA.
- Header word fields:
  - [31:28] opcode: 1 WRITE, 2 READ, 3 RUN, 4 STOP.
  - [27:26] target: 00 IM, 01 DM, 10 RF; 11 is illegal.
  - [15:0] count, in words.
- IDLE: accept header, latch its fields, then go to:
  - ADDR for WRITE or READ;
  - RUN for RUN;
  - RSP for STOP.
- ADDR: accept one start-address word. Then go to:
  - WR_DATA for WRITE;
  - RD_ISSUE for READ.
- WR_DATA, per accepted word:
  - drive the selected mau_address/write_data and pulse that target's mau_wren for exactly 1 cycle (the cycle after acceptance);
  - advance address by 4 and decrement the remaining count.
  - When the count is exhausted, go to RSP with ack = 32'hA000_0000 | count.
  - count=0: go to RSP directly after ADDR.
- RD_ISSUE → RD_WAIT → RD_SEND:
  - RD_ISSUE drives the address; RD_WAIT waits RD_LAT cycles, then captures the selected mau_read_data into rsp_data.
  - RD_SEND holds rsp_valid until rsp_ready, then advances address by 4 and either returns to RD_ISSUE or goes to IDLE when the count is exhausted.
  - Only one outstanding read at a time. count=0 returns to IDLE with no response.
- Errors (alive=1 for WRITE/READ/RUN, target 11, or unknown opcode):
  - the response is 32'hE000_0000 | header[27:0];
  - WRITE still consumes and discards its address word and count data words without pulsing wren, then responds with the error;
  - READ consumes its address word, then returns the single error word;
  - an unknown opcode responds immediately.
- RUN:
  - alive<=1 and the counter clears to 0 on entry; the counter increments every cycle while alive=1.
  - halt=1 sampled: respond {2'b10, cnt[29:0]}. alive stays 1 until STOP.
  - cnt==MAX_CYCLES without halt: alive<=0 in the same edge, respond {2'b01, cnt[29:0]}.
  - halt and timeout in the same cycle: halt wins.
  - cmd_ready=0 throughout RUN.
- STOP: alive<=0 in the cycle after header acceptance, respond 32'hA000_0000. Legal in any alive state.
- RSP: hold the response until it is accepted, then go to IDLE.
- All mau_* outputs are registered. Only the port set for the selected target toggles; the other two hold their values.
- Reset mid-operation aborts immediately: alive drops asynchronously and any pending response is lost.

Test Plan:
- WRITE IM, count 3, addr 0x10, data 11,22,33 → wren_im pulses at addresses 0x10/0x14/0x18 with matching data; rsp_data=0xA000_0003.
- READ RF, count 2, addr 0x04 with RD_LAT=2, host holds rsp_ready=0 for 5 cycles → rsp_data holds the RF word at 0x04 stable; then the RF word at 0x08 follows.
- RUN with halt asserted 100 cycles after alive rises → rsp_data=0x8000_0064 (±1 per the counting rule, checked exactly); alive stays 1; then STOP → alive=0, rsp_data=0xA000_0000.
- RUN with MAX_CYCLES=50 and halt never asserted → alive falls at cnt=50; rsp_data=0x4000_0032.
- WRITE DM issued while alive=1, count 2 → no wren_dm pulse, 3 words consumed, rsp_data=0xE400_0002; target 11 → error word.
- rst_n pulled low during WR_DATA and during RUN → all outputs 0 asynchronously; after release, state is IDLE and cmd_ready=1.

Source files
------------

// File: rtl/mau_controller.sv
// Host-side MAU initiator: loads IM/DM/RF while the CPU is held in reset,
// runs the CPU until halt or timeout, and streams read-back words to the host.
module mau_controller #(
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] MAX_CYCLES = 32'h00FF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] mau_address_im,
    output logic [31:0] mau_address_dm,
    output logic [31:0] mau_address_rf,
    output logic [31:0] mau_write_data_im,
    output logic [31:0] mau_write_data_dm,
    output logic [31:0] mau_write_data_rf,
    output logic        mau_wren_im,
    output logic        mau_wren_dm,
    output logic        mau_wren_rf,
    input  logic [31:0] mau_read_data_im,
    input  logic [31:0] mau_read_data_dm,
    input  logic [31:0] mau_read_data_rf,
    output logic        alive,
    input  logic        halt
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WR_DATA, S_RD_ISSUE, S_RD_WAIT, S_RD_SEND, S_RUN, S_RSP
    } state_t;

    localparam logic [3:0] OP_WRITE  = 4'd1;
    localparam logic [3:0] OP_READ   = 4'd2;
    localparam logic [3:0] OP_RUN    = 4'd3;
    localparam logic [3:0] OP_STOP   = 4'd4;
    localparam logic [1:0] TGT_IM    = 2'b00;
    localparam logic [1:0] TGT_DM    = 2'b01;
    localparam logic [1:0] TGT_RF    = 2'b10;
    localparam logic [1:0] TGT_BAD   = 2'b11;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t      state, state_next;
    logic [3:0]  op;
    logic [1:0]  tgt;
    logic [15:0] count;
    logic [15:0] remaining;
    logic [31:0] addr;
    logic        err;
    logic [27:0] hdr_low;
    logic [1:0]  wait_cnt;
    logic [31:0] cnt;

    logic        cmd_fire, rsp_fire, hdr_err;
    logic [3:0]  hdr_op;
    logic [1:0]  hdr_tgt;
    logic [31:0] rd_sel, err_word, ack_word;

    assign cmd_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_WR_DATA);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign hdr_op    = cmd_data[31:28];
    assign hdr_tgt   = cmd_data[27:26];
    assign err_word  = {4'hE, hdr_low};
    assign ack_word  = {16'hA000, count};

    // Classify an incoming header as illegal for the current alive state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hdr_err = 1'b0;
        case (hdr_op)
            OP_WRITE, OP_READ: hdr_err = alive || (hdr_tgt == TGT_BAD);
            OP_RUN:            hdr_err = alive;
            OP_STOP:           hdr_err = 1'b0;
            default:           hdr_err = 1'b1;
        endcase
    end

    // Select the read port of the latched target.
    always_comb begin
        rd_sel = 32'h0;
        case (tgt)
            TGT_IM:  rd_sel = mau_read_data_im;
            TGT_DM:  rd_sel = mau_read_data_dm;
            TGT_RF:  rd_sel = mau_read_data_rf;
            default: rd_sel = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (cmd_fire) begin
                case (hdr_op)
                    OP_WRITE, OP_READ: state_next = S_ADDR;
                    OP_RUN:            state_next = hdr_err ? S_RSP : S_RUN;
                    default:           state_next = S_RSP;
                endcase
            end
            S_ADDR: if (cmd_fire) begin
                if (op == OP_WRITE)   state_next = (count == 16'd0) ? S_RSP : S_WR_DATA;
                else if (err)         state_next = S_RSP;
                else                  state_next = (count == 16'd0) ? S_IDLE : S_RD_ISSUE;
            end
            S_WR_DATA:  if (cmd_fire && remaining == 16'd1) state_next = S_RSP;
            S_RD_ISSUE: state_next = S_RD_WAIT;
            S_RD_WAIT:  if (wait_cnt == WAIT_LAST) state_next = S_RD_SEND;
            S_RD_SEND:  if (rsp_fire) state_next = (remaining == 16'd1) ? S_IDLE : S_RD_ISSUE;
            S_RUN:      if (halt || cnt == MAX_CYCLES) state_next = S_RSP;
            S_RSP:      if (rsp_fire) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Datapath: command fields, MAU port registers, run counter and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op <= 4'h0;  tgt <= 2'b00;  count <= 16'h0;  remaining <= 16'h0;
            addr <= 32'h0;  err <= 1'b0;  hdr_low <= 28'h0;  wait_cnt <= 2'd0;
            cnt <= 32'h0;  alive <= 1'b0;  rsp_valid <= 1'b0;  rsp_data <= 32'h0;
            mau_address_im <= 32'h0;  mau_address_dm <= 32'h0;  mau_address_rf <= 32'h0;
            mau_write_data_im <= 32'h0;  mau_write_data_dm <= 32'h0;  mau_write_data_rf <= 32'h0;
            mau_wren_im <= 1'b0;  mau_wren_dm <= 1'b0;  mau_wren_rf <= 1'b0;
        end else begin
            mau_wren_im <= 1'b0;
            mau_wren_dm <= 1'b0;
            mau_wren_rf <= 1'b0;
            if (alive) cnt <= cnt + 32'd1;
            case (state)
                S_IDLE: if (cmd_fire) begin
                    op        <= hdr_op;
                    tgt       <= hdr_tgt;
                    count     <= cmd_data[15:0];
                    remaining <= cmd_data[15:0];
                    err       <= hdr_err;
                    hdr_low   <= cmd_data[27:0];
                    if (hdr_op == OP_STOP) begin
                        alive     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= 32'hA000_0000;
                    end else if (hdr_op == OP_RUN && !hdr_err) begin
                        alive <= 1'b1;
                        cnt   <= 32'h0;
                    end else if (hdr_op != OP_WRITE && hdr_op != OP_READ) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= {4'hE, cmd_data[27:0]};
                    end
                end
                S_ADDR: if (cmd_fire) begin
                    addr <= cmd_data;
                    if (op == OP_WRITE && count == 16'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= err ? err_word : ack_word;
                    end else if (op == OP_READ && err) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= err_word;
                    end
                end
                S_WR_DATA: if (cmd_fire) begin
                    if (!err) begin
                        case (tgt)
                            TGT_IM: begin mau_address_im <= addr; mau_write_data_im <= cmd_data; mau_wren_im <= 1'b1; end
                            TGT_DM: begin mau_address_dm <= addr; mau_write_data_dm <= cmd_data; mau_wren_dm <= 1'b1; end
                            TGT_RF: begin mau_address_rf <= addr; mau_write_data_rf <= cmd_data; mau_wren_rf <= 1'b1; end
                            default: ;
                        endcase
                    end
                    addr      <= addr + 32'd4;
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= err ? err_word : ack_word;
                    end
                end
                S_RD_ISSUE: begin
                    case (tgt)
                        TGT_IM:  mau_address_im <= addr;
                        TGT_DM:  mau_address_dm <= addr;
                        TGT_RF:  mau_address_rf <= addr;
                        default: ;
                    endcase
                    wait_cnt <= 2'd0;
                end
                S_RD_WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_cnt == WAIT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= rd_sel;
                    end
                end
                S_RD_SEND: if (rsp_fire) begin
                    rsp_valid <= 1'b0;
                    addr      <= addr + 32'd4;
                    remaining <= remaining - 16'd1;
                end
                S_RUN: begin
                    if (halt) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= {2'b10, cnt[29:0]};
                    end else if (cnt == MAX_CYCLES) begin
                        alive     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {2'b01, cnt[29:0]};
                    end
                end
                S_RSP: if (rsp_fire) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
